ldpc_var_cell: RTL and testbench

Parametrised LDPC variable-node cell: holds one channel LLR plus DEG stored check-to-variable (c2v) messages. Per iteration it accepts DEG new c2v messages serially, forms the posterior total, and emits DEG extrinsic variable-to-check (v2c) messages over a valid/ready stream. It also produces the hard decision. It sits between the channel-LLR loader and the check-node array, one instance per code bit.

---
 rtl/ldpc_var_cell.sv | 226 ++++++++++++++++++++++
 tb/tb_ldpc_var_cell.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_var_cell.sv
// ----------------------------------------------------------------------------
// ldpc_var_cell
//
// LDPC variable-node cell: one per code bit. It holds the channel LLR and
// the DEG check-to-variable (c2v) messages from the previous iteration.
// Each iteration it optionally absorbs DEG fresh c2v messages (serially,
// edge order 0..DEG-1), then streams out DEG extrinsic variable-to-check
// (v2c) messages, each equal to the posterior total minus that edge's own
// c2v message. The hard decision is the sign of the posterior total.
//
// Parameters
//   D_WID   LLR / message width, two's complement (default 8)
//   DEG     variable-node degree, 2..16 (default 3)
//
// Ports
//   clk        clock
//   reset_n    asynchronous active-low reset
//   load/din   load channel LLR (IDLE only; wins over start)
//   start/mode begin an iteration (IDLE only); mode 1 = accept c2v first,
//              mode 0 = emit from the stored state only
//   c2v_*      incoming check messages (valid/ready)
//   v2c_*      outgoing extrinsic messages (valid/ready)
//   hard_bit   1 when the posterior total is negative
//   busy       cell is not idle
//   done       one-cycle pulse after the last v2c handshake
//
// Configuration macro
//   LDPC_VAR_SAT_EN  defined: extrinsic outputs clamp symmetrically to
//                    +/-(2^(D_WID-1)-1). Undefined: they wrap to D_WID bits.
// ----------------------------------------------------------------------------
module ldpc_var_cell #(
    parameter int D_WID = 8,
    parameter int DEG   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [D_WID-1:0] din,
    input  logic             start,
    input  logic             mode,
    input  logic             c2v_valid,
    input  logic [D_WID-1:0] c2v_data,
    output logic             c2v_ready,
    output logic             v2c_valid,
    output logic [D_WID-1:0] v2c_data,
    input  logic             v2c_ready,
    output logic             hard_bit,
    output logic             busy,
    output logic             done
);

    // The accumulator holds llr plus DEG messages, i.e. DEG+1 terms, so the
    // extra clog2(DEG+1) bits keep it exact for any input pattern.
    localparam int S_WID   = D_WID + $clog2(DEG + 1);
    localparam int IDX_WID = $clog2(DEG);
    localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(DEG - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [D_WID-1:0]   llr_q, llr_d;
    logic [D_WID-1:0]   msg_q [DEG];
    logic [D_WID-1:0]   msg_d [DEG];
    logic [S_WID-1:0]   acc_q, acc_d;
    logic [IDX_WID-1:0] idx_q, idx_d;
    logic               hard_q, hard_d;
    logic               done_q, done_d;

    logic [D_WID-1:0]   msg_sel;
    logic [D_WID-1:0]   fit_val;

    // ------------------------------------------------------------------
    // Extrinsic message for the current edge
    // ------------------------------------------------------------------
    always_comb begin
        msg_sel = '0;
        for (int i = 0; i < DEG; i++) begin
            if (idx_q == IDX_WID'(i)) begin
                msg_sel = msg_q[i];
            end
        end
    end

`ifdef LDPC_VAR_SAT_EN
    // Symmetric clamp bounds; the most negative code is deliberately
    // excluded so that downstream negation never overflows.
    localparam logic signed [S_WID:0] SAT_MAX =
        {{(S_WID - D_WID + 2){1'b0}}, {(D_WID - 1){1'b1}}};
    localparam logic signed [S_WID:0] SAT_MIN = -SAT_MAX;

    logic signed [S_WID:0] ext;

    always_comb begin
        // One bit wider than acc so the subtraction itself cannot wrap.
        ext = {acc_q[S_WID-1], acc_q}
            - {{(S_WID + 1 - D_WID){msg_sel[D_WID-1]}}, msg_sel};
        if (ext > SAT_MAX) begin
            fit_val = SAT_MAX[D_WID-1:0];
        end else if (ext < SAT_MIN) begin
            fit_val = SAT_MIN[D_WID-1:0];
        end else begin
            fit_val = ext[D_WID-1:0];
        end
    end
`else
    // Wrap-around: only the low D_WID bits of the difference matter, and
    // those depend only on the low D_WID bits of the operands.
    always_comb begin
        fit_val = acc_q[D_WID-1:0] - msg_sel;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        llr_d   = llr_q;
        msg_d   = msg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        hard_d  = hard_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    // A fresh codeword: forget old check messages so a
                    // mode-0 iteration emits the bare channel LLR.
                    llr_d = din;
                    for (int i = 0; i < DEG; i++) begin
                        msg_d[i] = '0;
                    end
                    acc_d  = {{(S_WID - D_WID){din[D_WID-1]}}, din};
                    hard_d = din[D_WID-1];
                end else if (start) begin
                    idx_d = '0;
                    if (mode) begin
                        state_d = ST_ACC;
                        acc_d   = {{(S_WID - D_WID){llr_q[D_WID-1]}}, llr_q};
                    end else begin
                        // Re-emit from the posterior already held in acc.
                        state_d = ST_EMIT;
                    end
                end
            end

            ST_ACC: begin
                if (c2v_valid) begin
                    for (int i = 0; i < DEG; i++) begin
                        if (idx_q == IDX_WID'(i)) begin
                            msg_d[i] = c2v_data;
                        end
                    end
                    acc_d = acc_q + {{(S_WID - D_WID){c2v_data[D_WID-1]}}, c2v_data};
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        idx_d = idx_q + IDX_WID'(1);
                    end
                end
            end

            ST_EMIT: begin
                if (v2c_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        hard_d  = acc_q[S_WID-1];
                    end else begin
                        idx_d = idx_q + IDX_WID'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            llr_q   <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            hard_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEG; i++) begin
                msg_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            llr_q   <= llr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            hard_q  <= hard_d;
            done_q  <= done_d;
            for (int i = 0; i < DEG; i++) begin
                msg_q[i] <= msg_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign c2v_ready = (state_q == ST_ACC);
    assign v2c_valid = (state_q == ST_EMIT);
    // Zero outside EMIT so an idle cell presents a clean bus.
    assign v2c_data  = (state_q == ST_EMIT) ? fit_val : '0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hard_bit  = hard_q;

endmodule

// File: tb/tb_ldpc_var_cell.sv
`timescale 1ns/1ps
module tb_ldpc_var_cell;

    localparam int D_WID = 8;
    localparam int DEG   = 3;
    localparam int MAXV  = (1 << (D_WID - 1)) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             load = 1'b0;
    logic [D_WID-1:0] din = '0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic             c2v_valid = 1'b0;
    logic [D_WID-1:0] c2v_data = '0;
    logic             c2v_ready;
    logic             v2c_valid;
    logic [D_WID-1:0] v2c_data;
    logic             v2c_ready = 1'b0;
    logic             hard_bit;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    ldpc_var_cell #(.D_WID(D_WID), .DEG(DEG)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .din       (din),
        .start     (start),
        .mode      (mode),
        .c2v_valid (c2v_valid),
        .c2v_data  (c2v_data),
        .c2v_ready (c2v_ready),
        .v2c_valid (v2c_valid),
        .v2c_data  (v2c_data),
        .v2c_ready (v2c_ready),
        .hard_bit  (hard_bit),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_iter   = 0;

    // Behavioural reference: plain integers, no widths to worry about.
    int m_llr;
    int m_msg [DEG];
    int m_acc;
    int m_hard;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int sx(input logic [D_WID-1:0] x);
        logic signed [D_WID-1:0] s;
        s = x;
        return int'(s);
    endfunction

    function automatic int fit(input int v);
`ifdef LDPC_VAR_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < -MAXV) return -MAXV;
        return v;
`else
        logic signed [D_WID-1:0] t;
        t = v[D_WID-1:0];
        return int'(t);
`endif
    endfunction

    function automatic int rnd_msg();
        return int'($urandom_range(2 * MAXV + 1)) - (MAXV + 1);
    endfunction

    task automatic model_clear();
        m_llr  = 0;
        m_acc  = 0;
        m_hard = 0;
        for (int i = 0; i < DEG; i++) m_msg[i] = 0;
    endtask

    // All tasks start and end at a falling edge, where inputs change and
    // outputs are sampled.
    task automatic do_load(input int v);
        logic [31:0] b;
        b = v;
        load = 1'b1;
        din  = b[D_WID-1:0];
        @(negedge clk);
        load = 1'b0;
        m_llr = v;
        m_acc = v;
        m_hard = (v < 0) ? 1 : 0;
        for (int i = 0; i < DEG; i++) m_msg[i] = 0;
        check("load_hard", int'(hard_bit), m_hard);
        check("load_busy", int'(busy), 0);
    endtask

    task automatic do_start(input int m);
        start = 1'b1;
        mode  = m[0];
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_c2v_ready", int'(c2v_ready), m);
        check("start_v2c_valid", int'(v2c_valid), 1 - m);
    endtask

    task automatic do_acc(input int vals [DEG], input int gap_pct);
        int k = 0;
        int cyc = 0;
        logic [31:0] b;
        while (k < DEG && cyc < 200) begin
            check("acc_c2v_ready", int'(c2v_ready), 1);
            check("acc_v2c_valid", int'(v2c_valid), 0);
            if (int'($urandom_range(99)) < gap_pct) begin
                c2v_valid = 1'b0;
                c2v_data  = D_WID'($urandom);
            end else begin
                b = vals[k];
                c2v_valid = 1'b1;
                c2v_data  = b[D_WID-1:0];
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        c2v_valid = 1'b0;
        if (k < DEG) check("acc_timeout", k, DEG);
        m_acc = m_llr;
        for (int i = 0; i < DEG; i++) begin
            m_msg[i] = vals[i];
            m_acc += vals[i];
        end
    endtask

    task automatic do_emit(input int gap_pct, input int bp_at, input int junk);
        int k = 0;
        int cyc = 0;
        int held = 0;
        while (k < DEG && cyc < 200) begin
            check("emit_valid", int'(v2c_valid), 1);
            check("emit_data", sx(v2c_data), fit(m_acc - m_msg[k]));
            check("emit_hard_stable", int'(hard_bit), m_hard);
            check("emit_done_low", int'(done), 0);
            if (bp_at == k && held < 5) begin
                v2c_ready = 1'b0;
                held++;
            end else begin
                v2c_ready = (int'($urandom_range(99)) >= gap_pct);
            end
            // Stray load / c2v traffic must be ignored while emitting.
            load      = (junk != 0) ? 1'($urandom_range(1)) : 1'b0;
            din       = D_WID'($urandom);
            c2v_valid = (junk != 0) ? 1'($urandom_range(1)) : 1'b0;
            c2v_data  = D_WID'($urandom);
            if (v2c_ready) k++;
            @(negedge clk);
            cyc++;
        end
        v2c_ready = 1'b0;
        load      = 1'b0;
        c2v_valid = 1'b0;
        if (k < DEG) check("emit_timeout", k, DEG);
        m_hard = (m_acc < 0) ? 1 : 0;
        check("end_done", int'(done), 1);
        check("end_busy", int'(busy), 0);
        check("end_hard", int'(hard_bit), m_hard);
        check("end_v2c_valid", int'(v2c_valid), 0);
        @(negedge clk);
        check("done_pulse_width", int'(done), 0);
    endtask

    task automatic run_iter(input int m, input int vals [DEG], input int gap_pct,
                            input int bp_at, input int junk);
        do_start(m);
        if (m != 0) do_acc(vals, gap_pct);
        do_emit(gap_pct, bp_at, junk);
        n_iter++;
        $display("iter %0d mode=%0d llr=%0d acc=%0d hard=%0d",
                 n_iter, m, m_llr, m_acc, m_hard);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c2v_ready"}, int'(c2v_ready), 0);
        check({tag, "_v2c_valid"}, int'(v2c_valid), 0);
        check({tag, "_v2c_data"},  int'(v2c_data), 0);
        check({tag, "_hard_bit"},  int'(hard_bit), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_done"},      int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v [DEG];
        int z [DEG];
        for (int i = 0; i < DEG; i++) z[i] = 0;
        model_clear();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Channel LLR only
        do_load(10);
        run_iter(0, z, 0, -1, 0);

        // Accumulate 5,-20,3 with backpressure at edge 1
        v[0] = 5; v[1] = -20; v[2] = 3;
        run_iter(1, v, 0, 1, 0);

        // Large positive and negative sums
        do_load(100);
        v[0] = 100; v[1] = 100; v[2] = 100;
        run_iter(1, v, 30, -1, 0);
        do_load(-100);
        v[0] = -100; v[1] = -100; v[2] = -100;
        run_iter(1, v, 30, -1, 0);

        // Reset in the middle of ACC after two messages
        do_load(50);
        do_start(1);
        c2v_valid = 1'b1; c2v_data = D_WID'(9);
        @(negedge clk);
        c2v_data = D_WID'(-4);
        @(negedge clk);
        c2v_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(negedge clk);
        check_all_zero("post_reset");
        do_load(7);
        run_iter(0, z, 0, -1, 0);

        // load and start together: only the load takes effect
        load = 1'b1; start = 1'b1; mode = 1'b1; din = D_WID'(-33);
        @(negedge clk);
        load = 1'b0; start = 1'b0; mode = 1'b0;
        m_llr = -33; m_acc = -33; m_hard = 1;
        for (int i = 0; i < DEG; i++) m_msg[i] = 0;
        check("ld_st_busy", int'(busy), 0);
        check("ld_st_hard", int'(hard_bit), 1);
        @(negedge clk);
        check("ld_st_busy2", int'(busy), 0);
        check("ld_st_c2v_ready", int'(c2v_ready), 0);

        // Loads during EMIT are ignored; mode 1 then exposes llr
        run_iter(0, z, 20, -1, 1);
        v[0] = 0; v[1] = 1; v[2] = 2;
        run_iter(1, v, 20, -1, 1);

        // Randomised iterations
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2) == 0) do_load(rnd_msg());
            for (int i = 0; i < DEG; i++) begin
                if ($urandom_range(3) == 0)
                    v[i] = ($urandom_range(1) != 0) ? MAXV : -(MAXV + 1);
                else
                    v[i] = rnd_msg();
            end
            run_iter(int'($urandom_range(1)), v, int'($urandom_range(50)),
                     ($urandom_range(3) == 0) ? int'($urandom_range(DEG - 1)) : -1,
                     int'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
